// File: rtl/udma_stream_arbiter.sv
// Frame-aware N:1 round-robin merger of uDMA streams with an output FIFO.
// Optional lock timeout: define UDMA_STREAM_ARB_TIMEOUT_EN.
module udma_stream_arbiter #(
    parameter int N_STREAMS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TO_WIDTH   = 16,
    localparam int ID_W      = $clog2(N_STREAMS)
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [N_STREAMS-1:0]            cfg_en_i,
    input  logic [TO_WIDTH-1:0]             cfg_timeout_i,
    input  logic [N_STREAMS*DATA_WIDTH-1:0] in_data_i,
    input  logic [N_STREAMS*2-1:0]          in_datasize_i,
    input  logic [N_STREAMS-1:0]            in_valid_i,
    input  logic [N_STREAMS-1:0]            in_sot_i,
    input  logic [N_STREAMS-1:0]            in_eot_i,
    output logic [N_STREAMS-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [1:0]                      out_datasize_o,
    output logic [ID_W-1:0]                 out_src_id_o,
    output logic                            out_sot_o,
    output logic                            out_eot_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            busy_o,
    output logic                            timeout_evt_o
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_WIDTH + 2 + ID_W + 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_owner;
    logic [ID_W-1:0]     r_rr;

    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];

    logic [ID_W-1:0]     w_grant;
    logic                w_grant_vld;
    logic [ID_W-1:0]     w_sel;
    logic                w_sel_vld;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_eot;
    logic                w_timeout;
    logic [ENTRY_W-1:0]  w_entry;
    logic [ENTRY_W-1:0]  w_head;

    // Descending scan: the last hit wins, i.e. the first candidate after r_rr.
    always_comb begin
        int idx;
        w_grant     = '0;
        w_grant_vld = 1'b0;
        idx         = 0;
        for (int k = N_STREAMS; k >= 1; k--) begin
            idx = (int'(r_rr) + k) % N_STREAMS;
            if (cfg_en_i[idx] && in_valid_i[idx]) begin
                w_grant     = ID_W'(idx);
                w_grant_vld = 1'b1;
            end
        end
    end

    assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_grant;
    assign w_sel_vld = (r_state == ST_LOCKED) || w_grant_vld;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    generate
        for (genvar gi = 0; gi < N_STREAMS; gi++) begin : g_ready
            assign in_ready_o[gi] = w_sel_vld && !w_full && (w_sel == ID_W'(gi));
        end
    endgenerate

    assign w_push  = w_sel_vld && !w_full && in_valid_i[w_sel];
    assign w_pop   = !w_empty && out_ready_i;
    assign w_eot   = in_eot_i[w_sel];
    assign w_entry = {in_data_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH],
                      in_datasize_i[int'(w_sel)*2 +: 2],
                      w_sel, in_sot_i[w_sel], w_eot};

`ifdef UDMA_STREAM_ARB_TIMEOUT_EN
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                w_to_count;

    // Cycles stalled by a full FIFO are not the owner's fault and do not count.
    assign w_to_count = (r_state == ST_LOCKED) && !w_push && !w_full;
    assign w_timeout  = w_to_count && (cfg_timeout_i != '0) &&
                        (r_to_cnt == cfg_timeout_i - 1'b1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_to_cnt <= '0;
        end else if (r_state == ST_IDLE || w_push) begin
            r_to_cnt <= '0;
        end else if (w_to_count && (r_to_cnt != '1)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^cfg_timeout_i;
    assign w_timeout        = 1'b0;
`endif

    assign timeout_evt_o = w_timeout;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_rr    <= ID_W'(N_STREAMS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_push) begin
                        r_rr <= w_grant;
                        if (!w_eot) begin
                            r_state <= ST_LOCKED;
                            r_owner <= w_grant;
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((w_push && w_eot) || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Payload storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    assign out_data_o     = w_head[ENTRY_W-1 -: DATA_WIDTH];
    assign out_datasize_o = w_head[ID_W+3 -: 2];
    assign out_src_id_o   = w_head[ID_W+1 -: ID_W];
    assign out_sot_o      = w_head[1];
    assign out_eot_o      = w_head[0];
    assign out_valid_o    = !w_empty;
    assign busy_o         = (r_state == ST_LOCKED) || !w_empty;

endmodule

// File: tb/tb_udma_stream_arbiter.sv
// Directed, table-driven check of udma_stream_arbiter (N=2, depth 4),
// plus hand sequences for lock timeout and mid-frame reset.
module tb_udma_stream_arbiter;

`ifdef UDMA_STREAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic [1:0]  cfg_en;
    logic [15:0] cfg_timeout;
    logic [31:0] d0, d1;
    logic [3:0]  in_datasize;
    logic [1:0]  in_valid, in_sot, in_eot, in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_datasize;
    logic        out_src_id, out_sot, out_eot, out_valid, out_ready, busy, timeout_evt;

    int total = 0;
    int bad   = 0;

    udma_stream_arbiter #(
        .N_STREAMS (2),
        .DATA_WIDTH(32),
        .FIFO_DEPTH(4),
        .TO_WIDTH  (16)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .cfg_en_i      (cfg_en),
        .cfg_timeout_i (cfg_timeout),
        .in_data_i     ({d1, d0}),
        .in_datasize_i (in_datasize),
        .in_valid_i    (in_valid),
        .in_sot_i      (in_sot),
        .in_eot_i      (in_eot),
        .in_ready_o    (in_ready),
        .out_data_o    (out_data),
        .out_datasize_o(out_datasize),
        .out_src_id_o  (out_src_id),
        .out_sot_o     (out_sot),
        .out_eot_o     (out_eot),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .busy_o        (busy),
        .timeout_evt_o (timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  en, vld, sot, eot;
        logic [31:0] d0, d1;
        logic        ordy;
        logic [1:0]  x_rdy;
        logic        x_ov;
        logic [31:0] x_data;
        logic        x_src, x_sot, x_eot, x_busy;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [1:0] en, vld, sot, eot,
                                input logic [31:0] a0, a1, input logic ordy,
                                input logic [1:0] x_rdy, input logic x_ov,
                                input logic [31:0] x_data,
                                input logic x_src, x_sot, x_eot, x_busy);
        vec_t v;
        v.en = en; v.vld = vld; v.sot = sot; v.eot = eot;
        v.d0 = a0; v.d1 = a1; v.ordy = ordy;
        v.x_rdy = x_rdy; v.x_ov = x_ov; v.x_data = x_data;
        v.x_src = x_src; v.x_sot = x_sot; v.x_eot = x_eot; v.x_busy = x_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, vld, sot, eot, input logic [31:0] a0, a1,
                         input logic ordy);
        cfg_en = en; in_valid = vld; in_sot = sot; in_eot = eot;
        d0 = a0; d1 = a1; out_ready = ordy;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        cfg_timeout = 16'd0;
        tick;
        rstn = 1'b1;
    endtask

    initial begin
        string tag;
        rstn = 1'b0;
        in_datasize = 4'b1001;
        cfg_timeout = 16'd0;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
        #2;
        chk("rst_ready", {30'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_evt", {31'd0, timeout_evt}, 32'd0);
        tick;
        rstn = 1'b1;

        // 1: 3-beat frame from stream 0 while stream 1 waits
        vt.push_back(mk(2'b11,2'b11,2'b11,2'b10,32'hA0,32'hB0,1, 2'b01,0,32'h0 ,0,0,0,0));
        vt.push_back(mk(2'b11,2'b11,2'b10,2'b10,32'hA1,32'hB0,1, 2'b01,1,32'hA0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b11,2'b10,2'b11,32'hA2,32'hB0,1, 2'b01,1,32'hA1,0,0,0,1));
        vt.push_back(mk(2'b11,2'b10,2'b10,2'b10,32'h0 ,32'hB0,1, 2'b10,1,32'hA2,0,0,1,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,1,32'hB0,1,1,1,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,0,32'h0 ,0,0,0,0));
        // 2: single-beat frames on both streams alternate
        vt.push_back(mk(2'b11,2'b11,2'b11,2'b11,32'hC0,32'hD0,1, 2'b01,0,32'h0 ,0,0,0,0));
        vt.push_back(mk(2'b11,2'b11,2'b11,2'b11,32'hC1,32'hD0,1, 2'b10,1,32'hC0,0,1,1,1));
        vt.push_back(mk(2'b11,2'b11,2'b11,2'b11,32'hC1,32'hD1,1, 2'b01,1,32'hD0,1,1,1,1));
        vt.push_back(mk(2'b11,2'b11,2'b11,2'b11,32'hC2,32'hD1,1, 2'b10,1,32'hC1,0,1,1,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,1,32'hD1,1,1,1,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,0,32'h0 ,0,0,0,0));
        // 3: backpressure fills the FIFO, then drains in order
        vt.push_back(mk(2'b11,2'b01,2'b01,2'b00,32'hE0,32'h0 ,0, 2'b01,0,32'h0 ,0,0,0,0));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b00,32'hE1,32'h0 ,0, 2'b01,1,32'hE0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b00,32'hE2,32'h0 ,0, 2'b01,1,32'hE0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b00,32'hE3,32'h0 ,0, 2'b01,1,32'hE0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b01,32'hE4,32'h0 ,0, 2'b00,1,32'hE0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b01,32'hE4,32'h0 ,1, 2'b00,1,32'hE0,0,1,0,1));
        vt.push_back(mk(2'b11,2'b01,2'b00,2'b01,32'hE4,32'h0 ,1, 2'b01,1,32'hE1,0,0,0,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,1,32'hE2,0,0,0,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,1,32'hE3,0,0,0,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,1,32'hE4,0,0,1,1));
        vt.push_back(mk(2'b11,2'b00,2'b00,2'b00,32'h0 ,32'h0 ,1, 2'b00,0,32'h0 ,0,0,0,0));
        // 4: enable dropped mid-frame on stream 1; frame completes, next one is refused
        vt.push_back(mk(2'b11,2'b10,2'b10,2'b00,32'h0 ,32'hF0,1, 2'b10,0,32'h0 ,0,0,0,0));
        vt.push_back(mk(2'b01,2'b11,2'b01,2'b01,32'h90,32'hF1,1, 2'b10,1,32'hF0,1,1,0,1));
        vt.push_back(mk(2'b01,2'b11,2'b01,2'b11,32'h90,32'hF2,1, 2'b10,1,32'hF1,1,0,0,1));
        vt.push_back(mk(2'b01,2'b11,2'b11,2'b11,32'h90,32'h70,1, 2'b01,1,32'hF2,1,0,1,1));
        vt.push_back(mk(2'b01,2'b10,2'b10,2'b10,32'h0 ,32'h70,1, 2'b00,1,32'h90,0,1,1,1));
        vt.push_back(mk(2'b01,2'b10,2'b10,2'b10,32'h0 ,32'h70,1, 2'b00,0,32'h0 ,0,0,0,0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].en, vt[i].vld, vt[i].sot, vt[i].eot, vt[i].d0, vt[i].d1, vt[i].ordy);
            #4;
            tag = $sformatf("v%0d", i);
            chk({tag, "_ready"}, {30'd0, in_ready}, {30'd0, vt[i].x_rdy});
            chk({tag, "_ovalid"}, {31'd0, out_valid}, {31'd0, vt[i].x_ov});
            chk({tag, "_data"}, out_data, vt[i].x_data);
            chk({tag, "_src"}, {31'd0, out_src_id}, {31'd0, vt[i].x_src});
            chk({tag, "_sot"}, {31'd0, out_sot}, {31'd0, vt[i].x_sot});
            chk({tag, "_eot"}, {31'd0, out_eot}, {31'd0, vt[i].x_eot});
            chk({tag, "_busy"}, {31'd0, busy}, {31'd0, vt[i].x_busy});
            chk({tag, "_dsize"}, {30'd0, out_datasize},
                vt[i].x_ov ? {30'd0, (vt[i].x_src ? 2'b10 : 2'b01)} : 32'd0);
            tick;
        end

        // 5: owner stream 1 stalls after sot; lock released by timeout when enabled
        do_reset;
        cfg_timeout = 16'd8;
        drive(2'b11, 2'b10, 2'b10, 2'b00, 32'h0, 32'hAB, 1'b1);
        #4;
        chk("t5_grant", {30'd0, in_ready}, 32'd2);
        tick;
        for (int i = 1; i <= 8; i++) begin
            drive(2'b11, 2'b01, 2'b01, 2'b01, 32'hCD, 32'h0, 1'b1);
            #4;
            chk($sformatf("t5_lock_rdy%0d", i), {30'd0, in_ready}, 32'd2);
            chk($sformatf("t5_evt%0d", i), {31'd0, timeout_evt},
                (i == 8 && TO_EN) ? 32'd1 : 32'd0);
            tick;
        end
        #4;
        chk("t5_after_rdy", {30'd0, in_ready}, TO_EN ? 32'd1 : 32'd2);
        chk("t5_after_evt", {31'd0, timeout_evt}, 32'd0);
        tick;

        // 6: reset with three beats of a partial frame queued
        do_reset;
        drive(2'b11, 2'b01, 2'b01, 2'b00, 32'h51, 32'h0, 1'b0);
        tick;
        drive(2'b11, 2'b01, 2'b00, 2'b00, 32'h52, 32'h0, 1'b0);
        tick;
        drive(2'b11, 2'b01, 2'b00, 2'b00, 32'h53, 32'h0, 1'b0);
        tick;
        in_valid = 2'b00;
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_data", out_data, 32'h51);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        tick;
        rstn = 1'b1;
        drive(2'b11, 2'b11, 2'b11, 2'b11, 32'h61, 32'h62, 1'b1);
        #4;
        chk("t6_prio_rdy", {30'd0, in_ready}, 32'd1);
        tick;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
        #4;
        chk("t6_out_data", out_data, 32'h61);
        chk("t6_out_src", {31'd0, out_src_id}, 32'd0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
